inst_rom: RTL

Instruction memory responder: the far end of the PC fetch interface. It accepts the fetch enable and word address issued each cycle by the PC counter. It returns the addressed 32-bit instruction after a fixed registered latency, with a valid flag and an address-error flag. A program-load write port lets the bench or a boot loader fill the array.

---
 rtl/inst_rom_pkg.sv | 42 ++++
 rtl/inst_rom_bank.sv | 47 ++++
 rtl/inst_rom.sv | 117 +++++++++++
 3 files changed

// File: rtl/inst_rom_pkg.sv
// -----------------------------------------------------------------------------
// inst_rom_pkg
// Shared widths, constants and address-decode helpers for the instruction
// memory responder (inst_rom) and its storage bank (inst_rom_bank).
// No ports; imported with "import inst_rom_pkg::*;".
// -----------------------------------------------------------------------------
package inst_rom_pkg;

    localparam int          InstAddrBus    = 32;     // fetch/program address width
    localparam int          InstBus        = 32;     // instruction word width
    localparam int          InstMemNumLog2 = 10;     // default log2 of word count

    localparam logic [31:0] NopInst        = 32'h0000_0000;
    localparam logic [31:0] ZeroWord       = 32'h0000_0000;

    localparam logic        RstEnable      = 1'b1;
    localparam logic        ChipEnable     = 1'b1;
    localparam logic        ChipDisable    = 1'b0;

    // Word index of a byte address relative to the memory base. The
    // subtraction is modulo 2**32, so addresses below the base wrap to a
    // huge index and are rejected by addr_ok().
    function automatic logic [29:0] word_index(input logic [InstAddrBus-1:0] a,
                                               input logic [InstAddrBus-1:0] base);
        logic [InstAddrBus-1:0] off;
        off = a - base;
        return off[31:2];
    endfunction

    // True when the address is word aligned and falls inside the array.
    // The range test is done in 64 bits so depth_log2 up to 30 is safe.
    function automatic logic addr_ok(input logic [InstAddrBus-1:0] a,
                                     input logic [InstAddrBus-1:0] base,
                                     input int                     depth_log2);
        logic [InstAddrBus-1:0] off;
        logic [63:0]            words;
        off   = a - base;
        words = 64'(off) >> 2;
        return (a[1:0] == 2'b00) && (words < (64'd1 << depth_log2));
    endfunction

endpackage

// File: rtl/inst_rom_bank.sv
// -----------------------------------------------------------------------------
// inst_rom_bank
// Synchronous single-read/single-write word array with a registered read
// port. A read and write of the same index in one cycle returns the old word
// (read-before-write). Contents are never cleared.
// Ports:
//   clk        clock
//   rd_en_i    read enable; rd_data_o updates only when set
//   rd_idx_i   read word index
//   rd_data_o  registered read data
//   wr_en_i    write enable
//   wr_idx_i   write word index
//   wr_data_i  write data
// -----------------------------------------------------------------------------
module inst_rom_bank
    import inst_rom_pkg::*;
#(
    parameter int DEPTH_LOG2 = InstMemNumLog2
) (
    input  logic                  clk,
    input  logic                  rd_en_i,
    input  logic [DEPTH_LOG2-1:0] rd_idx_i,
    output logic [InstBus-1:0]    rd_data_o,
    input  logic                  wr_en_i,
    input  logic [DEPTH_LOG2-1:0] wr_idx_i,
    input  logic [InstBus-1:0]    wr_data_i
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [InstBus-1:0] mem_q [0:DEPTH-1];
    logic [InstBus-1:0] rd_data_q;

    // Both statements sample mem_q before the edge, which gives
    // read-before-write on a same-index collision.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_idx_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/inst_rom.sv
// -----------------------------------------------------------------------------
// inst_rom
// Instruction memory responder at the far end of the PC fetch interface.
// Each cycle with ce=1 the addressed word is returned after a fixed latency
// together with inst_valid; misaligned or out-of-range fetches return
// NOP_WORD with addr_err set. A program-load port fills the array and is
// honoured even while rst is asserted.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ce, addr          fetch enable and byte address (PC)
//   inst              fetched instruction
//   inst_valid        inst answers an enabled fetch
//   addr_err          answered fetch was misaligned / out of range
//   prog_we/addr/data program-load write port
// Build option: define INST_ROM_OUTREG_EN to add a second output register
// stage (latency 2 instead of 1).
// -----------------------------------------------------------------------------
module inst_rom
    import inst_rom_pkg::*;
#(
    parameter int                     DEPTH_LOG2 = InstMemNumLog2,
    parameter logic [InstAddrBus-1:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [InstBus-1:0]     NOP_WORD   = NopInst
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic [InstAddrBus-1:0] addr,
    output logic [InstBus-1:0]     inst,
    output logic                   inst_valid,
    output logic                   addr_err,
    input  logic                   prog_we,
    input  logic [InstAddrBus-1:0] prog_addr,
    input  logic [InstBus-1:0]     prog_data
);

    // ---------------- decode (shared rules for both ports) ----------------
    logic                  fetch_on;
    logic                  fetch_ok;
    logic                  fetch_hit;
    logic [DEPTH_LOG2-1:0] fetch_idx;
    logic                  wr_hit;
    logic [DEPTH_LOG2-1:0] wr_idx;

    assign fetch_on  = (ce == ChipEnable);
    assign fetch_ok  = addr_ok(addr, BASE_ADDR, DEPTH_LOG2);
    assign fetch_hit = fetch_on && fetch_ok;
    assign fetch_idx = DEPTH_LOG2'(word_index(addr, BASE_ADDR));

    assign wr_hit    = prog_we && addr_ok(prog_addr, BASE_ADDR, DEPTH_LOG2);
    assign wr_idx    = DEPTH_LOG2'(word_index(prog_addr, BASE_ADDR));

    // ---------------- storage ----------------
    logic [InstBus-1:0] bank_rd_data;

    inst_rom_bank #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_bank (
        .clk       (clk),
        .rd_en_i   (fetch_hit),
        .rd_idx_i  (fetch_idx),
        .rd_data_o (bank_rd_data),
        .wr_en_i   (wr_hit),
        .wr_idx_i  (wr_idx),
        .wr_data_i (prog_data)
    );

    // ---------------- stage 1 flags ----------------
    // The bank register itself is never reset; hit_q decides whether its
    // content is exposed, so a reset or a miss always yields NOP_WORD.
    logic               valid_q;
    logic               err_q;
    logic               hit_q;
    logic [InstBus-1:0] s1_inst_d;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            valid_q <= fetch_on;
            err_q   <= fetch_on && !fetch_ok;
            hit_q   <= fetch_hit;
        end
    end

    assign s1_inst_d = hit_q ? bank_rd_data : NOP_WORD;

`ifdef INST_ROM_OUTREG_EN
    // ---------------- optional stage 2 ----------------
    logic [InstBus-1:0] inst_q;
    logic               inst_valid_q;
    logic               addr_err_q;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            inst_q       <= NOP_WORD;
            inst_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            inst_q       <= s1_inst_d;
            inst_valid_q <= valid_q;
            addr_err_q   <= err_q;
        end
    end

    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign addr_err   = addr_err_q;
`else
    assign inst       = s1_inst_d;
    assign inst_valid = valid_q;
    assign addr_err   = err_q;
`endif

endmodule
